// File: rtl/byte_strip_pkg.sv
// rtl/byte_strip_pkg.sv - framing symbols and scheduler state encoding shared by the striper front end
package byte_strip_pkg;

    localparam logic [7:0] SYM_STP   = 8'hfb;
    localparam logic [7:0] SYM_SDP   = 8'h5c;
    localparam logic [7:0] SYM_END   = 8'hfd;
    localparam logic [7:0] SYM_EDB   = 8'hfe;
    localparam logic [7:0] SYM_COM   = 8'hbc;
    localparam logic [7:0] SYM_SKP   = 8'h1c;
    localparam logic [7:0] SYM_IDL   = 8'h7c;
    localparam logic [7:0] IDLE_DATA = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_PAD,
        ST_SKPOS
    } sched_state_t;

endpackage

// File: rtl/skp_timer.sv
// rtl/skp_timer.sv - slot counter that raises a pending SKP request every SKP_INTERVAL slots
module skp_timer #(
    parameter int SKP_INTERVAL = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_slot_end,
    input  logic i_clear,
    output logic o_pending
);

    localparam int CW = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0] COUNT_LAST = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] r_count;
    logic          r_pending;
    logic          w_wrap;

    assign w_wrap    = i_slot_end && (r_count == COUNT_LAST);
    assign o_pending = r_pending;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count   <= '0;
            r_pending <= 1'b0;
        end else begin
            if (i_slot_end) begin
                r_count <= w_wrap ? '0 : r_count + CW'(1);
            end
            // set happens on a slot's last lane, clear on lane 0, so they never collide
            if (w_wrap) begin
                r_pending <= 1'b1;
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stripe_scheduler.sv
// rtl/stripe_scheduler.sv - TLP/DLLP framing scheduler feeding the byte striper one symbol per clock
module stripe_scheduler
    import byte_strip_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int BITS         = 8,
    parameter int SKP_INTERVAL = 64
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_tlp_req,
    input  logic [BITS-1:0]           i_tlp_data,
    input  logic                      i_tlp_last,
    input  logic                      i_tlp_abort,
    output logic                      o_tlp_ack,
    input  logic                      i_dllp_req,
    input  logic [BITS-1:0]           i_dllp_data,
    input  logic                      i_dllp_last,
    output logic                      o_dllp_ack,
    output logic [BITS-1:0]           o_d,
    output logic                      o_dk,
    output logic [$clog2(LANES)-1:0]  o_lane_idx,
    output logic                      o_active
);

    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

    sched_state_t    r_state, w_next_state;
    logic [LW-1:0]   r_lane_nxt, r_lane_idx;
    logic            r_last_dllp, r_abort;
    logic [BITS-1:0] r_d, w_d, w_src_data;
    logic            r_dk, w_dk, r_active, w_active;
    logic            w_lane0, w_lane_last, w_last, w_pick_dllp;
    logic            w_take_grant, w_skp_clear, w_skp_pending;

    // r_last_dllp doubles as the current grant while in PAYLOAD/PAD
    assign w_lane0     = (r_lane_nxt == '0);
    assign w_lane_last = (r_lane_nxt == LANE_LAST);
    assign w_last      = r_last_dllp ? i_dllp_last : i_tlp_last;
    assign w_src_data  = r_last_dllp ? i_dllp_data : i_tlp_data;
    assign w_pick_dllp = i_dllp_req && (!i_tlp_req || !r_last_dllp);
    assign o_tlp_ack   = (r_state == ST_PAYLOAD) && !r_last_dllp && !i_reset;
    assign o_dllp_ack  = (r_state == ST_PAYLOAD) &&  r_last_dllp && !i_reset;

    assign o_d        = r_d;
    assign o_dk       = r_dk;
    assign o_lane_idx = r_lane_idx;
    assign o_active   = r_active;

    skp_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_slot_end (w_lane_last),
        .i_clear    (w_skp_clear),
        .o_pending  (w_skp_pending)
    );

    always_comb begin
        w_next_state = r_state;
        w_d          = BITS'(IDLE_DATA);
        w_dk         = 1'b1;
        w_active     = 1'b0;
        w_take_grant = 1'b0;
        w_skp_clear  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_lane0) begin
                    if (w_skp_pending) begin
                        w_d          = BITS'(SYM_COM);
                        w_dk         = 1'b0;
                        w_skp_clear  = 1'b1;
                        w_next_state = ST_SKPOS;
                    end else if (i_tlp_req || i_dllp_req) begin
                        w_d          = w_pick_dllp ? BITS'(SYM_SDP) : BITS'(SYM_STP);
                        w_dk         = 1'b0;
                        w_active     = 1'b1;
                        w_take_grant = 1'b1;
                        w_next_state = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                w_d      = w_src_data;
                w_active = 1'b1;
                if (w_last) begin
                    w_next_state = ST_PAD;
                end
            end
            ST_PAD: begin
                w_active = 1'b1;
                if (w_lane_last) begin
                    w_d          = r_abort ? BITS'(SYM_EDB) : BITS'(SYM_END);
                    w_dk         = 1'b0;
                    w_next_state = ST_IDLE;
                end
            end
            ST_SKPOS: begin
                w_d  = BITS'(SYM_SKP);
                w_dk = 1'b0;
                if (w_lane_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_lane_nxt  <= '0;
            r_last_dllp <= 1'b1;
            r_abort     <= 1'b0;
            r_d         <= BITS'(IDLE_DATA);
            r_dk        <= 1'b1;
            r_lane_idx  <= LANE_LAST;
            r_active    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_lane_nxt <= r_lane_nxt + LW'(1);
            r_d        <= w_d;
            r_dk       <= w_dk;
            r_lane_idx <= r_lane_nxt;
            r_active   <= w_active;
            if (w_take_grant) begin
                r_last_dllp <= w_pick_dllp;
            end
            if ((r_state == ST_PAYLOAD) && w_last) begin
                r_abort <= !r_last_dllp && i_tlp_abort;
            end
        end
    end

endmodule

// File: doc/stripe_scheduler.md
# stripe_scheduler

Framing scheduler that feeds the byte striper. It arbitrates between a TLP source and a DLLP source and wraps each packet in STP/SDP ... END/EDB, so that the start symbol always lands on lane 0 and the end symbol on lane LANES-1. It fills unused cycles with idle data and periodically inserts a SKP ordered set. Its D/DK/LANE_IDX outputs drive the striper's D/DK inputs, one byte per CLK.

## Interface
- LANES, 4: lane count; one slot = LANES consecutive bytes; power of two, ≥4.
- BITS, 8: symbol width.
- SKP_INTERVAL, 64: slots between SKP ordered-set requests; ≥2.
- CLK  in  1  single clock, all logic on posedge.
- RESET  in  1  synchronous, active-high.
- TLP_REQ  in  1  TLP source has a packet; held high until its LAST byte is acked.
- TLP_DATA  in  BITS  TLP payload byte.
- TLP_LAST  in  1  current TLP byte is final.
- TLP_ABORT  in  1  qualifies TLP_LAST; end the packet with EDB instead of END.
- TLP_ACK  out  1  combinational; TLP_DATA/LAST/ABORT consumed at this edge.
- DLLP_REQ, DLLP_DATA, DLLP_LAST, DLLP_ACK  same as TLP, without abort.
- D  out  BITS  registered symbol to striper.
- DK  out  1  registered; 0 = control symbol, 1 = data.
- LANE_IDX  out  clog2(LANES)  registered lane of current D.
- ACTIVE  out  1  registered; high while D carries STP/SDP through END/EDB inclusive.

## Operation
- Internal lane_nxt is the lane of the next byte to emit. It increments every edge and wraps LANES-1 → 0. Each edge emits exactly one byte.
- States: IDLE, PAYLOAD, PAD, SKPOS.
- IDLE: emit 8'h00, DK=1. At an edge with lane_nxt==0, decide in this order:
  - SKP pending: emit COM (DK=0), go to SKPOS.
  - Else, a requester with REQ high is granted: emit STP (TLP) or SDP (DLLP) with DK=0, ACTIVE=1, go to PAYLOAD.
  - If both request, round-robin against the last grant. The pointer resets to "TLP first".
  - If nothing qualifies, stay in IDLE.
- PAYLOAD: ACK of the granted source is high every cycle. Emit the source byte with DK=1. Sources never stall once granted.
- On the edge that consumes LAST, let L = lane_nxt of that byte. Next state depends on L:
  - L == LANES-2: emit END next.
  - Otherwise: go to PAD.
- PAD: emit 8'h00, DK=1 until the LANES-2 byte, then emit END (or EDB if ABORT was captured with LAST) with DK=0 at lane LANES-1. Then go to IDLE.
- A packet of n payload bytes (n ≥ 1) occupies ceil((n+2)/LANES) slots.
- SKPOS: emit SKP (DK=0) on lanes 1..LANES-1, then go to IDLE.
- SKP timer counts completed slots, incrementing on every emitted lane LANES-1 byte. On reaching SKP_INTERVAL-1 it sets pending and reloads 0. Pending is cleared when COM is emitted.
- SKP never preempts a packet. It waits for the next lane-0 decision in IDLE.
- REQ of a non-granted source is ignored mid-packet. Its ACK stays 0.

## Timing
- Reset values: D=8'h00, DK=1, LANE_IDX=LANES-1, ACTIVE=0, both ACKs 0. Internal state: IDLE, lane_nxt=0, skp count 0, pending 0, RR pointer set to TLP.
- REQ sampled at lane-0 edge T → STP/SDP on D in cycle T+1. First payload ACK is in cycle T+1; that byte appears on D in cycle T+2.
- ACK high in cycle t → the byte appears on D in cycle t+1.
- RESET mid-packet: the packet is abandoned with no END. The first post-reset output is idle on lane 0.
- REQ arriving at lane ≠ 0 waits for the next lane-0 edge, i.e. up to LANES-1 idle bytes.
- Pending SKP and both REQs all at the same edge: SKP wins, and the RR pointer is unchanged.

## Structure
- Shared package byte_strip_pkg holds:
  - Symbol constants STP 8'hfb, SDP 8'h5c, END 8'hfd, EDB 8'hfe, COM 8'hbc, SKP 8'h1c, IDL 8'h7c.
  - Idle data constant 8'h00.
  - The state encoding.
- Sub-module skp_timer: slot counter plus the pending flag, with set/clear ports.

## Test plan
- TLP A1..A5 requested at lane-0 edge → D: fb,A1,A2,A3 | A4,A5,00,fd; DK 0,1,1,1|1,1,1,0; ACTIVE high for 8 cycles.
- DLLP B1..B6 → 5c,B1..B3 | B4..B6,fd; no pad bytes.
- TLP of 3 bytes with ABORT on LAST → fb,A1,A2,A3 | 00,00,00,fe.
- TLP_REQ and DLLP_REQ held continuously → grants alternate: TLP, then DLLP, then TLP.
- SKP_INTERVAL=4 with no traffic → bc,1c,1c,1c every 4th slot. A packet in flight delays COM to the first lane-0 after its END.
- RESET asserted mid-payload for 1 cycle → ACK drops, LANE_IDX=3, D=00, DK=1. The next STP is on lane 0.
